stdout_line_arbiter: RTL and testbench

STDOUT_LINE_ARBITER -- requirements
Module: stdout_line_arbiter

---
 rtl/stdout_line_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_stdout_line_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_line_arbiter.sv
// stdout_line_arbiter: per-source character FIFOs feeding one output stream,
// granted a whole line at a time in round-robin order. A source whose FIFO is
// full without a newline is force-granted for at most DEPTH characters.
module stdout_line_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [$clog2(N_SRC)-1:0] in_src_i,
  input  logic [7:0]               in_char_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [$clog2(N_SRC)-1:0] out_src_o,
  output logic [7:0]               out_char_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [N_SRC-1:0]         drop_o
);

  localparam int unsigned SRC_W   = $clog2(N_SRC);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned BURST_W = (CNT_W > 6) ? CNT_W : 6;
  localparam logic [7:0]  NL_CHAR = 8'h0A;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem    [N_SRC][DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr [N_SRC];
  logic [PTR_W-1:0]   r_wr_ptr [N_SRC];
  logic [CNT_W-1:0]   r_count  [N_SRC];
  logic [CNT_W-1:0]   r_nl_cnt [N_SRC];
  logic [N_SRC-1:0]   r_drop;

  // Arbitration state
  state_t             r_state;
  logic [SRC_W-1:0]   r_grant;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic               r_force;
  logic [BURST_W-1:0] r_burst;

  // Per-source decode
  logic [7:0]         w_head    [N_SRC];
  logic [N_SRC-1:0]   w_full;
  logic [N_SRC-1:0]   w_empty;
  logic [N_SRC-1:0]   w_head_nl;
  logic [N_SRC-1:0]   w_elig;
  logic [N_SRC-1:0]   w_in_sel;
  logic [N_SRC-1:0]   w_g_sel;
  logic [N_SRC-1:0]   w_push;
  logic [N_SRC-1:0]   w_pop;
  logic [N_SRC-1:0]   w_drop_set;

  // Datapath / control
  logic               w_stream;
  logic               w_ready;
  logic               w_out_valid;
  logic [7:0]         w_out_char;
  logic               w_out_last;
  logic               w_xfer;
  logic               w_end;
  logic               w_found;
  logic [SRC_W-1:0]   w_next_grant;
  logic               w_next_force;
  logic [SRC_W-1:0]   w_rr_next;
  int unsigned        w_idx;

  assign w_stream = (r_state == ST_STREAM);

  // Per-source status: occupancy, head character, eligibility, index match
  always_comb begin
    for (int s = 0; s < N_SRC; s++) begin
      w_full[s]    = (r_count[s] == CNT_W'(DEPTH));
      w_empty[s]   = (r_count[s] == '0);
      w_head[s]    = r_mem[s][r_rd_ptr[s]];
      w_head_nl[s] = (w_head[s] == NL_CHAR);
      w_elig[s]    = (r_nl_cnt[s] != '0) || w_full[s];
      w_in_sel[s]  = (in_src_i == SRC_W'(s));
      w_g_sel[s]   = (r_grant == SRC_W'(s));
    end
  end

  // Input acceptance, output mux, push/pop/drop strobes
  always_comb begin
    w_ready     = 1'b1;
    w_out_valid = 1'b0;
    w_out_char  = '0;
    w_push      = '0;
    w_pop       = '0;
    w_drop_set  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (w_in_sel[s] && w_full[s]) begin
        w_ready = 1'b0;
      end
      if (w_stream && w_g_sel[s] && !w_empty[s]) begin
        w_out_valid = 1'b1;
        w_out_char  = w_head[s];
      end
    end
    w_xfer = w_out_valid && out_ready_i;
    for (int s = 0; s < N_SRC; s++) begin
      w_push[s]     = in_valid_i && w_in_sel[s] && !w_full[s];
      w_drop_set[s] = in_valid_i && w_in_sel[s] && w_full[s];
      w_pop[s]      = w_xfer && w_g_sel[s];
    end
  end

  assign w_out_last = w_out_valid && (w_out_char == NL_CHAR);

  // Burst end: newline transferred, or forced burst reached DEPTH transfers
  assign w_end = w_xfer &&
                 (w_out_last || (r_force && (r_burst == BURST_W'(DEPTH - 1))));

  assign w_rr_next = (r_grant == SRC_W'(N_SRC - 1)) ? '0 : (r_grant + SRC_W'(1));

  // Round-robin search for the first eligible source starting at rr_ptr
  always_comb begin
    w_found      = 1'b0;
    w_next_grant = '0;
    w_next_force = 1'b0;
    w_idx        = 0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx = 32'(r_rr_ptr) + 32'(i);
      if (w_idx >= N_SRC) begin
        w_idx = w_idx - N_SRC;
      end
      if (!w_found && w_elig[w_idx[SRC_W-1:0]]) begin
        w_found      = 1'b1;
        w_next_grant = w_idx[SRC_W-1:0];
        w_next_force = (r_nl_cnt[w_idx[SRC_W-1:0]] == '0);
      end
    end
  end

  // FIFO character storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < N_SRC; s++) begin
      if (w_push[s]) begin
        r_mem[s][r_wr_ptr[s]] <= in_char_i;
      end
    end
  end

  // FIFO pointers, occupancy and newline counts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_SRC; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_count[s]  <= '0;
        r_nl_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (w_push[s]) begin
          r_wr_ptr[s] <= r_wr_ptr[s] + PTR_W'(1);
        end
        if (w_pop[s]) begin
          r_rd_ptr[s] <= r_rd_ptr[s] + PTR_W'(1);
        end
        if (w_push[s] && !w_pop[s]) begin
          r_count[s] <= r_count[s] + CNT_W'(1);
        end else if (!w_push[s] && w_pop[s]) begin
          r_count[s] <= r_count[s] - CNT_W'(1);
        end
        if ((w_push[s] && (in_char_i == NL_CHAR)) && !(w_pop[s] && w_head_nl[s])) begin
          r_nl_cnt[s] <= r_nl_cnt[s] + CNT_W'(1);
        end else if (!(w_push[s] && (in_char_i == NL_CHAR)) && (w_pop[s] && w_head_nl[s])) begin
          r_nl_cnt[s] <= r_nl_cnt[s] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky overflow flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop <= '0;
    end else begin
      r_drop <= r_drop | w_drop_set;
    end
  end

  // Line arbiter FSM: grant in IDLE, stream one line (or forced chunk)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_force  <= 1'b0;
      r_burst  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_next_grant;
            r_force <= w_next_force;
            r_burst <= '0;
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_xfer) begin
            r_burst <= r_burst + BURST_W'(1);
          end
          if (w_end) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = w_ready;
  assign out_valid_o = w_out_valid;
  assign out_src_o   = r_grant;
  assign out_char_o  = w_out_char;
  assign out_last_o  = w_out_last;
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_stdout_line_arbiter.sv
// Bench for stdout_line_arbiter: queue-based reference model compared every
// cycle, directed line scenarios pinned with literal transfer logs, then
// randomized traffic.
module tb_stdout_line_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned SW = 2;
  localparam logic [7:0]  NL = 8'h0A;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [SW-1:0] in_src_i = '0;
  logic [7:0]    in_char_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [SW-1:0] out_src_o;
  logic [7:0]    out_char_o;
  logic          out_last_o;
  logic          out_ready_i = 1'b0;
  logic [N-1:0]  drop_o;

  stdout_line_arbiter #(.N_SRC(N), .DEPTH(D)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_src_i   (in_src_i),
    .in_char_i  (in_char_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_src_o  (out_src_o),
    .out_char_o (out_char_o),
    .out_last_o (out_last_o),
    .out_ready_i(out_ready_i),
    .drop_o     (drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one queue per source plus line-grant bookkeeping
  logic [7:0]   mq [N][$];
  bit           m_stream;
  int           m_grant;
  int           m_rr;
  bit           m_force;
  int           m_burst;
  logic [N-1:0] m_drop;

  // Log of model transfers (source, char, last, cycle)
  int lg_src[$];
  int lg_chr[$];
  int lg_last[$];
  int lg_cyc[$];
  int cyc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit has_nl(input int s);
    for (int k = 0; k < mq[s].size(); k++) begin
      if (mq[s][k] == NL) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < N; s++) mq[s].delete();
    m_stream = 0;
    m_grant  = 0;
    m_rr     = 0;
    m_force  = 0;
    m_burst  = 0;
    m_drop   = '0;
    lg_src.delete();
    lg_chr.delete();
    lg_last.delete();
    lg_cyc.delete();
    cyc = 0;
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock
  task automatic do_reset();
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_src_i    = SW'(2);
    rst_i       = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_last",  32'(out_last_o),  32'd0);
    chk("rst_out_char",  32'(out_char_o),  32'd0);
    chk("rst_out_src",   32'(out_src_o),   32'd0);
    chk("rst_drop",      32'(drop_o),      32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd1);
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One clock: drive inputs, compare DUT with model, advance model over the edge
  task automatic step(input logic v, input int src, input logic [7:0] ch, input logic ordy);
    logic       exp_rdy;
    logic       exp_v;
    logic       exp_last;
    logic [7:0] c;
    int         s;
    @(negedge clk_i);
    in_valid_i  = v;
    in_src_i    = SW'(src);
    in_char_i   = ch;
    out_ready_i = ordy;
    #1;
    cyc++;
    exp_rdy  = (mq[src].size() < D);
    exp_v    = m_stream && (mq[m_grant].size() != 0);
    exp_last = exp_v && (mq[m_grant][0] == NL);
    chk("in_ready",  32'(in_ready_o),  32'(exp_rdy));
    chk("out_valid", 32'(out_valid_o), 32'(exp_v));
    chk("out_last",  32'(out_last_o),  32'(exp_last));
    chk("drop",      32'(drop_o),      32'(m_drop));
    if (exp_v) begin
      chk("out_src",  32'(out_src_o),  32'(m_grant));
      chk("out_char", 32'(out_char_o), 32'(mq[m_grant][0]));
    end
    if (m_stream) begin
      if (exp_v && ordy) begin
        c = mq[m_grant].pop_front();
        m_burst++;
        lg_src.push_back(m_grant);
        lg_chr.push_back(int'(c));
        lg_last.push_back(int'(c == NL));
        lg_cyc.push_back(cyc);
        if (c == NL || (m_force && m_burst == D)) begin
          m_stream = 0;
          m_rr     = (m_grant + 1) % N;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        s = (m_rr + i) % N;
        if (has_nl(s) || mq[s].size() == D) begin
          m_grant  = s;
          m_force  = !has_nl(s);
          m_burst  = 0;
          m_stream = 1;
          break;
        end
      end
    end
    if (v) begin
      if (exp_rdy) mq[src].push_back(ch);
      else         m_drop[src] = 1'b1;
    end
  endtask

  task automatic chk_log(input string name, input int i, input int src, input int ch, input int last);
    if (i >= lg_src.size()) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: transfer %0d actual=absent required=present", name, i);
    end else begin
      chk(name, 32'(lg_src[i]),  32'(src));
      chk(name, 32'(lg_chr[i]),  32'(ch));
      chk(name, 32'(lg_last[i]), 32'(last));
    end
  endtask

  task automatic write_str(input int src, input string str, input logic ordy);
    for (int i = 0; i < str.len(); i++) step(1'b1, src, str[i], ordy);
  endtask

  task automatic idle_steps(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, ordy);
  endtask

  task automatic random_phase(input int n, input int nl_mod);
    logic [7:0] ch;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      ch = ($urandom_range(0, nl_mod - 1) == 0) ? NL : 8'(32'h20 + $urandom_range(0, 94));
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, N - 1)), ch,
           ($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    model_clear();

    // Single line from source 1 with downstream always ready
    do_reset();
    write_str(1, "hi\n", 1'b1);
    idle_steps(6, 1'b1);
    chk("a_count", 32'(lg_src.size()), 32'd3);
    chk_log("a_h",  0, 1, 8'h68, 0);
    chk_log("a_i",  1, 1, 8'h69, 0);
    chk_log("a_nl", 2, 1, 8'h0A, 1);
    if (lg_cyc.size() == 3) begin
      chk("a_first_cyc", 32'(lg_cyc[0]), 32'd5);
      chk("a_consec1",   32'(lg_cyc[1] - lg_cyc[0]), 32'd1);
      chk("a_consec2",   32'(lg_cyc[2] - lg_cyc[1]), 32'd1);
    end

    // Round-robin order across queued lines, one bubble between lines
    do_reset();
    write_str(0, "ab\n", 1'b0);
    write_str(2, "ab\n", 1'b0);
    write_str(3, "c\n", 1'b0);
    write_str(0, "e\n", 1'b0);
    idle_steps(30, 1'b1);
    chk("b_count", 32'(lg_src.size()), 32'd10);
    chk_log("b_0a",  0, 0, 8'h61, 0);
    chk_log("b_0b",  1, 0, 8'h62, 0);
    chk_log("b_0nl", 2, 0, 8'h0A, 1);
    chk_log("b_2a",  3, 2, 8'h61, 0);
    chk_log("b_2nl", 5, 2, 8'h0A, 1);
    chk_log("b_3c",  6, 3, 8'h63, 0);
    chk_log("b_3nl", 7, 3, 8'h0A, 1);
    chk_log("b_0e",  8, 0, 8'h65, 0);
    if (lg_cyc.size() >= 4) chk("b_bubble", 32'(lg_cyc[3] - lg_cyc[2]), 32'd2);

    // Full FIFO without newline: forced burst of DEPTH chars, overflow drop
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, 3, 8'(32'h30 + i), 1'b0);
    step(1'b1, 3, 8'h55, 1'b0);
    chk("c_ready_full", 32'(in_ready_o), 32'd0);
    step(1'b0, 3, 8'h00, 1'b0);
    chk("c_drop_set", 32'(drop_o), 32'b1000);
    idle_steps(25, 1'b1);
    chk("c_count", 32'(lg_src.size()), 32'd16);
    chk_log("c_first", 0,  3, 8'h30, 0);
    chk_log("c_last",  15, 3, 8'h3F, 0);
    chk("c_idle_after", 32'(out_valid_o), 32'd0);
    chk("c_drop_sticky", 32'(drop_o), 32'b1000);

    // Stalling downstream while another source pushes concurrently
    do_reset();
    write_str(0, "abc\n", 1'b0);
    for (int k = 0; k < 12; k++) step((k < 2), 1, (k == 0) ? 8'h78 : 8'h79, ((k % 2) == 0));
    chk("d_count", 32'(lg_src.size()), 32'd4);
    chk_log("d_a",  0, 0, 8'h61, 0);
    chk_log("d_b",  1, 0, 8'h62, 0);
    chk_log("d_c",  2, 0, 8'h63, 0);
    chk_log("d_nl", 3, 0, 8'h0A, 1);

    // Reset in the middle of a line discards it and clears drop flags
    do_reset();
    write_str(0, "abc\n", 1'b0);
    for (int i = 0; i <= D; i++) step(1'b1, 2, 8'h41, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0);
    chk("e_drop_pre", 32'(drop_o), 32'b0100);
    step(1'b0, 0, 8'h00, 1'b1);
    chk("e_one_xfer", 32'(lg_src.size()), 32'd1);
    chk_log("e_a", 0, 0, 8'h61, 0);
    do_reset();
    write_str(0, "x\n", 1'b1);
    idle_steps(6, 1'b1);
    chk("e_count", 32'(lg_src.size()), 32'd2);
    chk_log("e_x",  0, 0, 8'h78, 0);
    chk_log("e_nl", 1, 0, 8'h0A, 1);

    // Randomized traffic: short lines, then long lines that force bursts
    do_reset();
    random_phase(2500, 5);
    random_phase(2500, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
